// File: rtl/sdc_host_port.sv
// sdc_host_port: host-side front end for the SDRAM controller agent.
// Queues burst commands and write data, issues one request at a time.
module sdc_host_port #(
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int WD_DEPTH  = 16
) (
    input  logic              mclk,
    input  logic              s_reset,
    input  logic              hst_cmd_valid,
    output logic              hst_cmd_ready,
    input  logic              hst_cmd_wr_n,
    input  logic [ADDR_W-1:0] hst_cmd_adr,
    input  logic [1:0]        hst_cmd_len,
    input  logic              hst_wd_valid,
    output logic              hst_wd_ready,
    input  logic [DATA_W-1:0] hst_wd_data,
    input  logic [3:0]        hst_wd_en_n,
    output logic              hst_rd_valid,
    output logic [DATA_W-1:0] hst_rd_data,
    output logic              hst_rd_last,
    input  logic              sdr_init_done,
    output logic              sdr_req,
    output logic [ADDR_W-1:0] sdr_req_adr,
    output logic [1:0]        sdr_req_len,
    output logic              sdr_req_wr_n,
    input  logic              sdr_req_ack,
    input  logic              sdr_wr_next,
    output logic [DATA_W-1:0] sdr_wr_data,
    output logic [3:0]        sdr_wr_en_n,
    input  logic              sdr_rd_valid,
    input  logic [DATA_W-1:0] sdr_rd_data,
    output logic              busy,
    output logic              err_underrun
);

    localparam int CA = $clog2(CMD_DEPTH);
    localparam int WA = $clog2(WD_DEPTH);
    localparam int CW = ADDR_W + 3;
    localparam int WW = DATA_W + 4;

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

    state_t state_q, state_d;

    logic [CW-1:0] cmd_mem_q [CMD_DEPTH];
    logic [CA:0]   cmd_wp_q, cmd_rp_q;
    logic [WW-1:0] wd_mem_q [WD_DEPTH];
    logic [WA:0]   wd_wp_q, wd_rp_q;

    logic [1:0] cnt_q, cnt_d, cnt_eff;

    logic              sdr_req_q;
    logic [ADDR_W-1:0] sdr_req_adr_q;
    logic [1:0]        sdr_req_len_q;
    logic              sdr_req_wr_n_q;
    logic              hst_rd_valid_q;
    logic [DATA_W-1:0] hst_rd_data_q;
    logic              hst_rd_last_q;
    logic              err_q;

    logic cmd_empty, cmd_full, cmd_push;
    logic wd_empty, wd_full, wd_push;
    logic [WA:0] wd_cnt, wd_need;
    logic [CW-1:0] cmd_head;
    logic [WW-1:0] wd_head;
    logic head_wr_n;
    logic [1:0] head_len;
    logic [ADDR_W-1:0] head_adr;

    logic launch, wbeat, rbeat, beat_last, err_set;

    assign cmd_empty = cmd_wp_q == cmd_rp_q;
    assign cmd_full  = (cmd_wp_q[CA] != cmd_rp_q[CA]) &&
                       (cmd_wp_q[CA-1:0] == cmd_rp_q[CA-1:0]);
    assign wd_empty  = wd_wp_q == wd_rp_q;
    assign wd_full   = (wd_wp_q[WA] != wd_rp_q[WA]) &&
                       (wd_wp_q[WA-1:0] == wd_rp_q[WA-1:0]);
    assign wd_cnt    = wd_wp_q - wd_rp_q;

    assign hst_cmd_ready = !cmd_full;
    assign hst_wd_ready  = !wd_full;
    assign cmd_push      = hst_cmd_valid && !cmd_full;
    assign wd_push       = hst_wd_valid && !wd_full;

    assign cmd_head  = cmd_mem_q[cmd_rp_q[CA-1:0]];
    assign head_wr_n = cmd_head[CW-1];
    assign head_len  = cmd_head[CW-2 -: 2];
    assign head_adr  = cmd_head[ADDR_W-1:0];
    assign wd_need   = {{(WA-1){1'b0}}, head_len} + (WA+1)'(1);

    assign wd_head     = wd_mem_q[wd_rp_q[WA-1:0]];
    assign sdr_wr_data = wd_empty ? '0 : wd_head[DATA_W-1:0];
    assign sdr_wr_en_n = wd_empty ? 4'hF : wd_head[WW-1 -: 4];

    // FIFO storage; contents need no reset, only the pointers do
    always_ff @(posedge mclk) begin
        if (cmd_push)
            cmd_mem_q[cmd_wp_q[CA-1:0]] <= {hst_cmd_wr_n, hst_cmd_len, hst_cmd_adr};
        if (wd_push)
            wd_mem_q[wd_wp_q[WA-1:0]] <= {hst_wd_en_n, hst_wd_data};
    end

    // FIFO pointers: command pops on launch, write data pops on each taken beat
    always_ff @(posedge mclk) begin
        if (s_reset) begin
            cmd_wp_q <= '0;
            cmd_rp_q <= '0;
            wd_wp_q  <= '0;
            wd_rp_q  <= '0;
        end else begin
            if (cmd_push) cmd_wp_q <= cmd_wp_q + 1'b1;
            if (launch)   cmd_rp_q <= cmd_rp_q + 1'b1;
            if (wd_push)  wd_wp_q  <= wd_wp_q + 1'b1;
            if (wbeat)    wd_rp_q  <= wd_rp_q + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge mclk) begin
        if (s_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM control decode: launch, beat acceptance and stray-beat detection
    always_comb begin
        launch  = 1'b0;
        wbeat   = 1'b0;
        rbeat   = 1'b0;
        cnt_eff = cnt_q;
        unique case (state_q)
            IDLE: launch = sdr_init_done && !cmd_empty &&
                           (head_wr_n || wd_cnt >= wd_need);
            REQ: begin
                // a beat arriving with the ack is the first beat
                cnt_eff = 2'd0;
                wbeat = sdr_req_ack && !sdr_req_wr_n_q &&
                        sdr_wr_next && !wd_empty;
                rbeat = sdr_req_ack && sdr_req_wr_n_q && sdr_rd_valid;
            end
            WDATA: wbeat = sdr_wr_next && !wd_empty;
            RDATA: rbeat = sdr_rd_valid;
            default: ;
        endcase
        beat_last = (wbeat || rbeat) && (cnt_eff == sdr_req_len_q);
        err_set = (sdr_wr_next && (wd_empty ||
                   !(state_q == WDATA || state_q == REQ))) ||
                  (sdr_rd_valid && !(state_q == RDATA || state_q == REQ));
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (launch) state_d = REQ;
            REQ: begin
                if (sdr_req_ack) begin
                    if (beat_last)           state_d = IDLE;
                    else if (sdr_req_wr_n_q) state_d = RDATA;
                    else                     state_d = WDATA;
                end
            end
            WDATA: if (beat_last) state_d = IDLE;
            RDATA: if (beat_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat counter next value; restarts at ack and never runs past len
    always_comb begin
        cnt_d = cnt_q;
        if (beat_last)
            cnt_d = 2'd0;
        else if (state_q == REQ && sdr_req_ack)
            cnt_d = (wbeat || rbeat) ? 2'd1 : 2'd0;
        else if (wbeat || rbeat)
            cnt_d = cnt_q + 2'd1;
    end

    // Beat counter register
    always_ff @(posedge mclk) begin
        if (s_reset) cnt_q <= 2'd0;
        else         cnt_q <= cnt_d;
    end

    // Registered request, read return and sticky error outputs
    always_ff @(posedge mclk) begin
        if (s_reset) begin
            sdr_req_q      <= 1'b0;
            sdr_req_adr_q  <= '0;
            sdr_req_len_q  <= 2'd0;
            sdr_req_wr_n_q <= 1'b1;
            hst_rd_valid_q <= 1'b0;
            hst_rd_data_q  <= '0;
            hst_rd_last_q  <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            if (launch) begin
                sdr_req_q      <= 1'b1;
                sdr_req_adr_q  <= head_adr;
                sdr_req_len_q  <= head_len;
                sdr_req_wr_n_q <= head_wr_n;
            end else if (state_q == REQ && sdr_req_ack) begin
                sdr_req_q <= 1'b0;
            end
            hst_rd_valid_q <= rbeat;
            hst_rd_last_q  <= rbeat && beat_last;
            if (rbeat)   hst_rd_data_q <= sdr_rd_data;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign sdr_req      = sdr_req_q;
    assign sdr_req_adr  = sdr_req_adr_q;
    assign sdr_req_len  = sdr_req_len_q;
    assign sdr_req_wr_n = sdr_req_wr_n_q;
    assign hst_rd_valid = hst_rd_valid_q;
    assign hst_rd_data  = hst_rd_data_q;
    assign hst_rd_last  = hst_rd_last_q;
    assign err_underrun = err_q;
    assign busy         = (state_q != IDLE) || !cmd_empty;

endmodule

// File: tb/tb_sdc_host_port.sv
// tb_sdc_host_port: directed stimulus with a queue-based reference model
// compared against the DUT on every falling clock edge.
module tb_sdc_host_port;

    logic        mclk = 1'b0;
    logic        s_reset;
    logic        hst_cmd_valid;
    logic        hst_cmd_ready;
    logic        hst_cmd_wr_n;
    logic [22:0] hst_cmd_adr;
    logic [1:0]  hst_cmd_len;
    logic        hst_wd_valid;
    logic        hst_wd_ready;
    logic [31:0] hst_wd_data;
    logic [3:0]  hst_wd_en_n;
    logic        hst_rd_valid;
    logic [31:0] hst_rd_data;
    logic        hst_rd_last;
    logic        sdr_init_done;
    logic        sdr_req;
    logic [22:0] sdr_req_adr;
    logic [1:0]  sdr_req_len;
    logic        sdr_req_wr_n;
    logic        sdr_req_ack;
    logic        sdr_wr_next;
    logic [31:0] sdr_wr_data;
    logic [3:0]  sdr_wr_en_n;
    logic        sdr_rd_valid;
    logic [31:0] sdr_rd_data;
    logic        busy;
    logic        err_underrun;

    sdc_host_port dut (
        .mclk(mclk), .s_reset(s_reset),
        .hst_cmd_valid(hst_cmd_valid), .hst_cmd_ready(hst_cmd_ready),
        .hst_cmd_wr_n(hst_cmd_wr_n), .hst_cmd_adr(hst_cmd_adr),
        .hst_cmd_len(hst_cmd_len),
        .hst_wd_valid(hst_wd_valid), .hst_wd_ready(hst_wd_ready),
        .hst_wd_data(hst_wd_data), .hst_wd_en_n(hst_wd_en_n),
        .hst_rd_valid(hst_rd_valid), .hst_rd_data(hst_rd_data),
        .hst_rd_last(hst_rd_last),
        .sdr_init_done(sdr_init_done), .sdr_req(sdr_req),
        .sdr_req_adr(sdr_req_adr), .sdr_req_len(sdr_req_len),
        .sdr_req_wr_n(sdr_req_wr_n), .sdr_req_ack(sdr_req_ack),
        .sdr_wr_next(sdr_wr_next), .sdr_wr_data(sdr_wr_data),
        .sdr_wr_en_n(sdr_wr_en_n), .sdr_rd_valid(sdr_rd_valid),
        .sdr_rd_data(sdr_rd_data), .busy(busy),
        .err_underrun(err_underrun)
    );

    always #5 mclk = ~mclk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        wr_n;
        logic [22:0] adr;
        logic [1:0]  len;
    } cmd_t;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  en;
    } wd_t;

    cmd_t mcmd[$];
    wd_t  mwd[$];
    cmd_t cur;
    wd_t  wtmp;
    int   ph = 0;   // 0 idle, 1 awaiting ack, 2 moving data
    int   ph0, done, csz, wsz;
    bit   cpush, wpush, act_w, act_r;
    bit          m_req = 0, m_wrn = 1, m_rv = 0, m_rl = 0, m_err = 0;
    logic [22:0] m_adr = '0;
    logic [1:0]  m_len = '0;
    logic [31:0] m_rd = '0;

    always @(posedge mclk) begin
        if (s_reset) begin
            mcmd.delete();
            mwd.delete();
            ph = 0; done = 0;
            m_req = 0; m_adr = '0; m_len = '0; m_wrn = 1;
            m_rv = 0; m_rl = 0; m_rd = '0; m_err = 0;
        end else begin
            csz = mcmd.size();
            wsz = mwd.size();
            ph0 = ph;
            cpush = hst_cmd_valid && (csz < 4);
            wpush = hst_wd_valid && (wsz < 16);
            m_rv = 0; m_rl = 0;
            act_w = 0; act_r = 0;
            if (sdr_wr_next && (ph0 == 0 || wsz == 0 || (ph0 == 2 && cur.wr_n)))
                m_err = 1;
            if (sdr_rd_valid && (ph0 == 0 || (ph0 == 2 && !cur.wr_n)))
                m_err = 1;
            if (ph0 == 0) begin
                if (sdr_init_done && csz > 0 &&
                    (mcmd[0].wr_n || wsz >= mcmd[0].len + 1)) begin
                    cur = mcmd.pop_front();
                    m_req = 1; m_adr = cur.adr; m_len = cur.len; m_wrn = cur.wr_n;
                    ph = 1;
                end
            end else if (ph0 == 1) begin
                if (sdr_req_ack) begin
                    m_req = 0; done = 0; ph = 2;
                    act_w = !cur.wr_n; act_r = cur.wr_n;
                end
            end else begin
                act_w = !cur.wr_n; act_r = cur.wr_n;
            end
            if (act_w && sdr_wr_next && wsz > 0) begin
                wtmp = mwd.pop_front();
                done++;
                if (done == cur.len + 1) ph = 0;
            end
            if (act_r && sdr_rd_valid) begin
                m_rv = 1; m_rd = sdr_rd_data;
                m_rl = (done == cur.len);
                done++;
                if (done == cur.len + 1) ph = 0;
            end
            if (cpush) mcmd.push_back({hst_cmd_wr_n, hst_cmd_adr, hst_cmd_len});
            if (wpush) mwd.push_back({hst_wd_data, hst_wd_en_n});
        end
    end

    // Compare every cycle away from the active edge
    always @(negedge mclk) begin
        if (chk_en) begin
            chk("cmd_ready", hst_cmd_ready, mcmd.size() < 4);
            chk("wd_ready", hst_wd_ready, mwd.size() < 16);
            chk("req", sdr_req, m_req);
            chk("req_adr", sdr_req_adr, m_adr);
            chk("req_len", sdr_req_len, m_len);
            chk("req_wr_n", sdr_req_wr_n, m_wrn);
            chk("wr_data", sdr_wr_data, mwd.size() > 0 ? mwd[0].d : 32'h0);
            chk("wr_en_n", sdr_wr_en_n, mwd.size() > 0 ? mwd[0].en : 4'hF);
            chk("rd_valid", hst_rd_valid, m_rv);
            chk("rd_data", hst_rd_data, m_rd);
            chk("rd_last", hst_rd_last, m_rl);
            chk("busy", busy, (ph != 0) || (mcmd.size() > 0));
            chk("err", err_underrun, m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic push_cmd(logic wr_n, logic [22:0] adr, logic [1:0] len);
        hst_cmd_valid = 1; hst_cmd_wr_n = wr_n;
        hst_cmd_adr = adr; hst_cmd_len = len;
        tick();
        hst_cmd_valid = 0;
    endtask

    task automatic push_wd(logic [31:0] d, logic [3:0] en);
        hst_wd_valid = 1; hst_wd_data = d; hst_wd_en_n = en;
        tick();
        hst_wd_valid = 0;
    endtask

    task automatic wait_req(int lim);
        int n = 0;
        while (!sdr_req && n < lim) begin
            tick();
            n++;
        end
        chk("req_timeout", sdr_req, 1);
    endtask

    task automatic ack();
        sdr_req_ack = 1;
        tick();
        sdr_req_ack = 0;
    endtask

    task automatic rd_beat(logic [31:0] d);
        sdr_rd_valid = 1; sdr_rd_data = d;
        tick();
        sdr_rd_valid = 0;
    endtask

    logic [31:0] aw [4];
    logic [31:0] rdw [3];

    initial begin
        s_reset = 1; hst_cmd_valid = 0; hst_cmd_wr_n = 1;
        hst_cmd_adr = '0; hst_cmd_len = '0;
        hst_wd_valid = 0; hst_wd_data = '0; hst_wd_en_n = 4'hF;
        sdr_init_done = 0; sdr_req_ack = 0; sdr_wr_next = 0;
        sdr_rd_valid = 0; sdr_rd_data = '0;
        aw[0] = 32'hA000_0000; aw[1] = 32'hA000_0001;
        aw[2] = 32'hA000_0002; aw[3] = 32'hA000_0003;
        rdw[0] = 32'h1111_0000; rdw[1] = 32'h2222_0001; rdw[2] = 32'h3333_0002;

        tick();
        chk_en = 1;
        tick();
        s_reset = 0;
        chk("rst_req", sdr_req, 0);
        chk("rst_wr_n", sdr_req_wr_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", hst_cmd_ready, 1);

        // read held off by init_done
        push_cmd(1, 23'h00ABC, 2);
        tick(); tick();
        chk("noinit_req", sdr_req, 0);
        chk("noinit_busy", busy, 1);
        sdr_init_done = 1;
        tick();
        chk("init_req", sdr_req, 1);
        chk("init_adr", sdr_req_adr, 23'h00ABC);
        chk("init_len", sdr_req_len, 2);
        ack();
        chk("ack_drop", sdr_req, 0);
        for (int i = 0; i < 3; i++) begin
            rd_beat(rdw[i]);
            chk("r3_valid", hst_rd_valid, 1);
            chk("r3_data", hst_rd_data, rdw[i]);
            chk("r3_last", hst_rd_last, i == 2);
        end
        chk("r3_idle", busy, 0);

        // write, len 3: launch only once all four words are buffered
        push_cmd(0, 23'h12345, 3);
        for (int i = 0; i < 4; i++) begin
            push_wd(aw[i], 4'h0);
            chk("w_hold", sdr_req, 0);
        end
        tick();
        chk("w_req", sdr_req, 1);
        chk("w_adr", sdr_req_adr, 23'h12345);
        chk("w_wr_n", sdr_req_wr_n, 0);
        tick(); tick();
        ack();
        chk("w_drop", sdr_req, 0);
        for (int i = 0; i < 4; i++) begin
            chk("w_word", sdr_wr_data, aw[i]);
            chk("w_en", sdr_wr_en_n, 4'h0);
            sdr_wr_next = 1;
            tick();
            sdr_wr_next = 0;
            tick();
        end
        chk("w_idle", busy, 0);
        chk("w_wd_ready", hst_wd_ready, 1);
        chk("w_err", err_underrun, 0);

        // read, len 1, beats on non-consecutive cycles
        push_cmd(1, 23'h00100, 1);
        wait_req(10);
        ack();
        rd_beat(32'hD0D0_D0D0);
        chk("r1_v0", hst_rd_valid, 1);
        chk("r1_d0", hst_rd_data, 32'hD0D0_D0D0);
        chk("r1_l0", hst_rd_last, 0);
        tick(); tick();
        chk("r1_gap", hst_rd_valid, 0);
        rd_beat(32'hD1D1_D1D1);
        chk("r1_v1", hst_rd_valid, 1);
        chk("r1_d1", hst_rd_data, 32'hD1D1_D1D1);
        chk("r1_l1", hst_rd_last, 1);

        // command FIFO fill and drain
        sdr_init_done = 0;
        tick();
        for (int i = 0; i < 4; i++)
            push_cmd(1, 23'h200 + 23'(i), 0);
        chk("full_ready", hst_cmd_ready, 0);
        push_cmd(1, 23'h7FF, 0);
        chk("full_still", hst_cmd_ready, 0);
        sdr_init_done = 1;
        for (int i = 0; i < 4; i++) begin
            wait_req(10);
            chk("drain_adr", sdr_req_adr, 23'h200 + 23'(i));
            ack();
            rd_beat(32'hBEEF_0000 + 32'(i));
            chk("drain_last", hst_rd_last, 1);
        end
        tick();
        chk("drain_idle", busy, 0);

        // stray write beat while idle
        push_wd(32'hCAFE_F00D, 4'h5);
        sdr_wr_next = 1;
        tick();
        sdr_wr_next = 0;
        chk("stray_err", err_underrun, 1);
        chk("stray_nopop", sdr_wr_data, 32'hCAFE_F00D);
        chk("stray_en", sdr_wr_en_n, 4'h5);
        s_reset = 1;
        tick();
        s_reset = 0;
        chk("rst_err", err_underrun, 0);
        chk("rst_wd_empty", sdr_wr_data, 0);

        // reset in the middle of a read burst
        push_wd(32'h5555_AAAA, 4'h3);
        push_cmd(1, 23'h03456, 3);
        wait_req(10);
        ack();
        rd_beat(32'h0BAD_0001);
        chk("mid_v", hst_rd_valid, 1);
        s_reset = 1;
        tick();
        chk("mid_req", sdr_req, 0);
        chk("mid_valid", hst_rd_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_wd", sdr_wr_en_n, 4'hF);
        sdr_rd_valid = 1; sdr_rd_data = 32'h0BAD_0002;
        tick();
        s_reset = 0; sdr_rd_valid = 0;
        chk("mid_ignored", hst_rd_valid, 0);
        tick(); tick();
        chk("mid_noerr", err_underrun, 0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdc_host_port.md
Name: sdc_host_port

Overview:
- Host-side front end that sits directly upstream of the SDRAM controller agent and drives its sdr_* host interface.
- Queues host burst commands and write data in small FIFOs.
- Issues one request at a time using the controller's req/ack handshake.
- Sources write beats on sdr_wr_next and returns read beats to the host with a last-beat marker.

Parameters:
ADDR_W, 23, request address width; equals U_ADDR_MSB+1
DATA_W, 32, data width; equals U_DATA_MSB+1
CMD_DEPTH, 4, command FIFO entries; power of 2
WD_DEPTH, 16, write-data FIFO entries; power of 2, at least 4

Ports:
mclk  in  1  clock
s_reset  in  1  synchronous reset, active-high
hst_cmd_valid  in  1  host command valid
hst_cmd_ready  out  1  command FIFO not full
hst_cmd_wr_n  in  1  0=write, 1=read
hst_cmd_adr  in  ADDR_W  burst start address
hst_cmd_len  in  2  beats minus 1 (0..3 gives 1..4 beats)
hst_wd_valid  in  1  write data valid
hst_wd_ready  out  1  write-data FIFO not full
hst_wd_data  in  DATA_W  write word
hst_wd_en_n  in  4  byte enables, active-low
hst_rd_valid  out  1  read beat valid (no backpressure)
hst_rd_data  out  DATA_W  read word
hst_rd_last  out  1  final beat of a read burst
sdr_init_done  in  1  controller init complete
sdr_req  out  1  request to controller
sdr_req_adr  out  ADDR_W  request address
sdr_req_len  out  2  request length
sdr_req_wr_n  out  1  request direction
sdr_req_ack  in  1  controller accepted request
sdr_wr_next  in  1  controller consumes sdr_wr_data this cycle
sdr_wr_data  out  DATA_W  current write word
sdr_wr_en_n  out  4  current byte enables
sdr_rd_valid  in  1  controller read beat valid
sdr_rd_data  in  DATA_W  controller read word
busy  out  1  FSM not IDLE or command FIFO non-empty
err_underrun  out  1  sticky protocol error

Behaviour:
- Reset state (s_reset sampled high at the mclk edge): both FIFOs emptied; FSM=IDLE; beat counter=0; err_underrun cleared.
- Reset values of registered outputs: sdr_req=0, sdr_req_adr=0, sdr_req_len=0, sdr_req_wr_n=1, hst_rd_valid=0, hst_rd_data=0, hst_rd_last=0.
- Reset mid-burst abandons the burst with no further beats. The controller must be reset in the same cycle.
- Command FIFO push: hst_cmd_valid & hst_cmd_ready. hst_cmd_ready = not full; no bypass.
- Write-data FIFO push: hst_wd_valid & hst_wd_ready. It is show-ahead: sdr_wr_data/sdr_wr_en_n are combinational from the head entry, or 0/4'hF when empty.
- Push and pop in the same cycle are legal on both FIFOs. On a full FIFO, ready stays low that cycle.
- FSM state IDLE:
  - Launch when sdr_init_done=1, the command FIFO is non-empty, and either head.wr_n=1 or the write-data count is at least head.len+1.
  - On launch: pop the command, register adr/len/wr_n onto sdr_req_*, set sdr_req=1, go to REQ.
  - A write command never launches before all its data is buffered.
- FSM state REQ:
  - Hold sdr_req and sdr_req_* stable until sdr_req_ack=1.
  - On ack: sdr_req=0 from the next cycle, beat counter=0, go to WDATA (wr_n=0) or RDATA (wr_n=1).
  - An ack seen in the same cycle as the first sdr_wr_next/sdr_rd_valid also counts that beat.
- FSM state WDATA:
  - Each sdr_wr_next pops one word and increments the counter.
  - After beat len+1 (counter==len on a pop), go to IDLE.
- FSM state RDATA:
  - Each sdr_rd_valid is registered to the host: hst_rd_valid=1 and hst_rd_data=sdr_rd_data one cycle later.
  - hst_rd_last=1 on the beat where counter==len. After it, go to IDLE.
  - Read latency is exactly 1 cycle.
- Stray-beat errors set err_underrun (sticky until reset):
  - sdr_wr_next outside WDATA/REQ, or with the FIFO empty: no pop.
  - sdr_rd_valid outside RDATA/REQ: not forwarded.
- Only one outstanding request. The next launch may occur in the cycle after returning to IDLE, so the minimum request gap is 1 cycle.
- Counter: 2 bits, compared to the registered sdr_req_len; no wrap beyond len.
- FIFO pointers: log2(depth)+1 bits, wrapping modulo 2×depth. Full when MSBs differ and LSBs are equal.

Test Plan:
- Reset, then sdr_init_done=0 with a read command queued → sdr_req stays 0 and busy=1. Raise init_done → sdr_req=1 the next cycle with the queued adr/len.
- Write, len=3, adr=0x12345: push 4 words A0..A3 (en_n=0) → req issued only after the 4th word is buffered. Ack after 2 cycles → sdr_req drops; 4 sdr_wr_next pulses see A0..A3 in order; FSM returns to IDLE and hst_wd_ready=1.
- Read, len=1: ack, then sdr_rd_valid with D0 and D1 on non-consecutive cycles → hst_rd_valid one cycle after each; hst_rd_last=1 only with D1.
- Command FIFO fill: push 5 commands with init_done=0 → hst_cmd_ready=0 after 4. Enable init → all 4 drain in order, each with a 1-cycle minimum gap.
- sdr_wr_next pulsed while IDLE → err_underrun=1 and no pop; a subsequent s_reset clears it.
- s_reset asserted in RDATA after 1 of 4 beats → next cycle sdr_req=0, hst_rd_valid=0, FIFOs empty; a later beat is ignored and no flag is set.
